// File: rtl/bin_to_gray_counter.sv
// Registered binary up/down counter with a Gray-coded copy of the count.
// bin_q and gray_q are loaded on the same edge, so they always agree with each other.
module bin_to_gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             step
);

  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;
  logic             next_step;

  // Next count. Priority is load, then enable, then hold.
  // wrap is decided from the count before the step.
  always_comb begin
    next_bin  = bin_q;
    next_wrap = 1'b0;
    next_step = 1'b0;
    if (load) begin
      next_bin = load_bin;
    end else if (en) begin
      next_step = 1'b1;
      if (dir) begin
        next_bin  = bin_q + WIDTH'(1);
        next_wrap = &bin_q;
      end else begin
        next_bin  = bin_q - WIDTH'(1);
        next_wrap = ~|bin_q;
      end
    end
  end

  // Encode the new count, not the current one, so gray_q matches bin_q in the same cycle.
  always_comb begin
    next_gray = next_bin ^ (next_bin >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap   <= 1'b0;
      step   <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= next_gray;
      wrap   <= next_wrap;
      step   <= next_step;
    end
  end

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Scoreboard bench for bin_to_gray_counter (WIDTH=4), using directed vectors.
// Expected values are written out by hand in the vector list.
module tb_bin_to_gray_counter;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         w;
    logic         s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         dir = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] bin_q;
  logic [W-1:0] gray_q;
  logic         wrap;
  logic         step;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  bin_to_gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_bin(load_bin), .bin_q(bin_q), .gray_q(gray_q),
    .wrap(wrap), .step(step)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs 3 time units after a rising edge and queue the expected result.
  task automatic drive(input logic r, input logic e, input logic d, input logic l,
                       input logic [W-1:0] lb, input logic [W-1:0] eb,
                       input logic [W-1:0] eg, input logic ew, input logic es);
    exp_t x;
    @(posedge clk);
    #3;
    rst = r; en = e; dir = d; load = l; load_bin = lb;
    x.b = eb; x.g = eg; x.w = ew; x.s = es;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one unit after every rising edge, compare the outputs with the oldest queued entry.
  initial begin : monitor
    exp_t         x;
    logic [W-1:0] prev_gray;
    logic         have_prev;
    have_prev = 1'b0;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("bin_q", bin_q, x.b);
        check("gray_q", gray_q, x.g);
        check("wrap", W'(wrap), W'(x.w));
        check("step", W'(step), W'(x.s));
        check("gray_consistency", gray_q, bin_q ^ (bin_q >> 1));
        if (x.s && have_prev)
          check("gray_one_bit", W'($countones(gray_q ^ prev_gray)), W'(1));
        prev_gray = gray_q;
        have_prev = 1'b1;
      end
    end
  end

  initial begin : stimulus
    bit drained;
    // Reset held with en=1, dir=1.
    drive(1, 1, 1, 0, 4'h0, 4'b0000, 4'b0000, 0, 0);
    drive(1, 1, 1, 0, 4'h0, 4'b0000, 4'b0000, 0, 0);
    // Count up through the full cycle; wrap only on 1111 -> 0000.
    drive(0, 1, 1, 0, 4'h0, 4'd1,  4'b0001, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd2,  4'b0011, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd3,  4'b0010, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd4,  4'b0110, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd5,  4'b0111, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd6,  4'b0101, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd7,  4'b0100, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd8,  4'b1100, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd9,  4'b1101, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd10, 4'b1111, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd11, 4'b1110, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd12, 4'b1010, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd13, 4'b1011, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd14, 4'b1001, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd15, 4'b1000, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd0,  4'b0000, 1, 1);
    // Count down from 0, which wraps to all ones.
    drive(0, 1, 0, 0, 4'h0, 4'd15, 4'b1000, 1, 1);
    drive(0, 1, 0, 0, 4'h0, 4'd14, 4'b1001, 0, 1);
    // Load takes priority over enable.
    drive(0, 1, 1, 1, 4'b1010, 4'd10, 4'b1111, 0, 0);
    drive(0, 1, 1, 0, 4'h0,    4'd11, 4'b1110, 0, 1);
    // Count up through the wrap to 0101.
    drive(0, 1, 1, 0, 4'h0, 4'd12, 4'b1010, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd13, 4'b1011, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd14, 4'b1001, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd15, 4'b1000, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd0,  4'b0000, 1, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd1,  4'b0001, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd2,  4'b0011, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd3,  4'b0010, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd4,  4'b0110, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd5,  4'b0111, 0, 1);
    // Hold for three cycles.
    drive(0, 0, 1, 0, 4'h0, 4'd5, 4'b0111, 0, 0);
    drive(0, 0, 0, 0, 4'h0, 4'd5, 4'b0111, 0, 0);
    drive(0, 0, 1, 0, 4'h0, 4'd5, 4'b0111, 0, 0);
    // Reverse direction every cycle.
    drive(0, 1, 0, 0, 4'h0, 4'd4, 4'b0110, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd5, 4'b0111, 0, 1);
    drive(0, 1, 0, 0, 4'h0, 4'd4, 4'b0110, 0, 1);
    drive(0, 1, 1, 0, 4'h0, 4'd5, 4'b0111, 0, 1);
    // Reach 1100, then assert reset together with load; reset wins.
    drive(0, 0, 1, 1, 4'b1011, 4'd11, 4'b1110, 0, 0);
    drive(0, 1, 1, 0, 4'h0,    4'd12, 4'b1010, 0, 1);
    drive(1, 1, 1, 1, 4'b1111, 4'd0,  4'b0000, 0, 0);
    // Counting resumes from 0 after reset is released.
    drive(0, 1, 1, 0, 4'h0, 4'd1, 4'b0001, 0, 1);
    drive(0, 1, 0, 0, 4'h0, 4'd0, 4'b0000, 0, 1);
    drive(0, 0, 0, 0, 4'h0, 4'd0, 4'b0000, 0, 0);

    drained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    total++;
    if (!drained) begin
      bad++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
